// File: rtl/apb_param_regfile.sv
// apb_param_regfile: parametrised APB4 slave register file.
// Every register has an access type fixed at elaboration. The register file
// supports byte strobes, a fixed number of wait states, error responses,
// per-register hardware update ports, write pulses and a W1C-derived interrupt.
module apb_param_regfile #(
  parameter int                         NUM_REGS  = 8,
  parameter int                         DATA_W    = 32,
  parameter int                         ADDR_W    = 8,
  parameter int                         WAIT_CYC  = 0,
  parameter logic [NUM_REGS*3-1:0]      REG_TYPE  = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [DATA_W-1:0]            pwdata,
  input  logic [DATA_W/8-1:0]          pstrb,
  output logic [DATA_W-1:0]            prdata,
  output logic                         pready,
  output logic                         pslverr,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_wdata,
  input  logic [NUM_REGS-1:0]          hw_we,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          wr_pulse,
  output logic                         irq
);

  localparam int STRB_W = DATA_W / 8;

  localparam logic [2:0] T_RW  = 3'd0;
  localparam logic [2:0] T_RO  = 3'd1;
  localparam logic [2:0] T_WO  = 3'd2;
  localparam logic [2:0] T_W1S = 3'd3;
  localparam logic [2:0] T_W1C = 3'd4;
  localparam logic [2:0] T_W1P = 3'd5;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Access code of register i.
  function automatic logic [2:0] type_of(input int i);
    return REG_TYPE[3*i +: 3];
  endfunction

  // Codes 6 and 7 behave exactly like RO.
  function automatic logic is_ro(input logic [2:0] t);
    return (t == T_RO) || (t == 3'd6) || (t == 3'd7);
  endfunction

  // WO and W1P contents are never exposed on the bus.
  function automatic logic is_readable(input logic [2:0] t);
    return (t != T_WO) && (t != T_W1P);
  endfunction

  state_t                     state_r;
  state_t                     state_next_s;
  logic [3:0]                 cnt_r;
  logic [3:0]                 cnt_next_s;
  logic [ADDR_W-1:0]          idx_s;
  logic                       hit_s;
  logic [NUM_REGS-1:0]        sel_onehot_s;
  logic [2:0]                 sel_type_s;
  logic [DATA_W-1:0]          rd_val_s;
  logic                       err_s;
  logic                       commit_s;
  logic                       wr_ok_s;
  logic [DATA_W-1:0]          strb_mask_s;
  logic [NUM_REGS-1:0]        irq_bits_s;

  // pready is a pure decode of the registered FSM state.
  assign pready   = (state_r == ACCESS) && (cnt_r == WAIT_LAST);
  // A transfer whose psel has dropped never commits.
  assign commit_s = pready && psel;
  assign wr_ok_s  = commit_s && pwrite && !err_s;
  assign idx_s    = {2'b00, paddr[ADDR_W-1:2]};
  assign pslverr  = pready && err_s;
  assign irq      = |irq_bits_s;

  // FSM state and wait counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state and wait counter logic for the APB phases.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      IDLE: begin
        cnt_next_s = 4'd0;
        if (psel && !penable) begin
          state_next_s = SETUP;
        end else begin
          state_next_s = IDLE;
        end
      end
      SETUP: begin
        state_next_s = ACCESS;
        cnt_next_s   = 4'd0;
      end
      ACCESS: begin
        if (!psel) begin
          state_next_s = IDLE;
          cnt_next_s   = 4'd0;
        end else if (pready) begin
          cnt_next_s = 4'd0;
          if (!penable) begin
            state_next_s = SETUP;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = ACCESS;
          cnt_next_s   = cnt_r + 4'd1;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // Address decode: one-hot select, access type and current value of the target.
  always_comb begin
    hit_s        = 1'b0;
    sel_onehot_s = '0;
    sel_type_s   = T_RO;
    rd_val_s     = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx_s == ADDR_W'(i)) begin
        hit_s           = 1'b1;
        sel_onehot_s[i] = 1'b1;
        sel_type_s      = type_of(i);
        rd_val_s        = reg_q[i*DATA_W +: DATA_W];
      end else begin
        sel_onehot_s[i] = 1'b0;
      end
    end
  end

  // Error on misalignment, out-of-range index or a write to a read-only register.
  always_comb begin
    if (paddr[1:0] != 2'b00) begin
      err_s = 1'b1;
    end else if (!hit_s) begin
      err_s = 1'b1;
    end else if (pwrite && is_ro(sel_type_s)) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end

  // Read data is driven only during a successful read completion.
  always_comb begin
    if (pready && !pwrite && !err_s && is_readable(sel_type_s)) begin
      prdata = rd_val_s;
    end else begin
      prdata = '0;
    end
  end

  // Expand byte strobes into a bit mask.
  always_comb begin
    strb_mask_s = '0;
    for (int b = 0; b < STRB_W; b++) begin
      strb_mask_s[8*b +: 8] = {8{pstrb[b]}};
    end
  end

  // One-cycle pulse following every accepted software write.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_pulse <= '0;
    end else if (wr_ok_s) begin
      wr_pulse <= sel_onehot_s;
    end else begin
      wr_pulse <= '0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    localparam logic [2:0] TYPE = REG_TYPE[3*g +: 3];

    logic [DATA_W-1:0] q_r;
    logic [DATA_W-1:0] nxt_s;
    logic [DATA_W-1:0] hw_s;
    logic [DATA_W-1:0] sw_m_s;
    logic [DATA_W-1:0] sw_d_s;
    logic              sw_we_s;
    logic              unused_hw_s;

    assign hw_s    = hw_wdata[g*DATA_W +: DATA_W];
    assign sw_we_s = wr_ok_s && sel_onehot_s[g];
    assign sw_m_s  = sw_we_s ? strb_mask_s : '0;
    assign sw_d_s  = pwdata & sw_m_s;
    // WO and W1P registers have no hardware update path.
    assign unused_hw_s = ^{hw_s, hw_we[g]};

    // Next register value from the software and hardware update rules of this type.
    always_comb begin
      nxt_s = q_r;
      case (TYPE)
        T_RW: begin
          // Software-written lanes override a simultaneous hardware load.
          if (hw_we[g]) begin
            nxt_s = (hw_s & ~sw_m_s) | sw_d_s;
          end else begin
            nxt_s = (q_r & ~sw_m_s) | sw_d_s;
          end
        end
        T_WO: begin
          nxt_s = (q_r & ~sw_m_s) | sw_d_s;
        end
        T_W1S: begin
          if (hw_we[g]) begin
            nxt_s = q_r | sw_d_s | hw_s;
          end else begin
            nxt_s = q_r | sw_d_s;
          end
        end
        T_W1C: begin
          // Hardware set is applied after the software clear so no event is lost.
          if (hw_we[g]) begin
            nxt_s = (q_r & ~sw_d_s) | hw_s;
          end else begin
            nxt_s = q_r & ~sw_d_s;
          end
        end
        T_W1P: begin
          if (sw_we_s) begin
            nxt_s = (q_r & ~sw_m_s) | sw_d_s;
          end else begin
            nxt_s = '0;
          end
        end
        default: begin
          if (hw_we[g]) begin
            nxt_s = hw_s;
          end else begin
            nxt_s = q_r;
          end
        end
      endcase
    end

    // Register storage with its elaboration-time reset value.
    always_ff @(posedge clk) begin
      if (rst) begin
        q_r <= RESET_VAL[g*DATA_W +: DATA_W];
      end else begin
        q_r <= nxt_s;
      end
    end

    assign reg_q[g*DATA_W +: DATA_W] = q_r;
    assign irq_bits_s[g] = (TYPE == T_W1C) ? (|q_r) : 1'b0;
  end

endmodule

// File: tb/tb_apb_param_regfile.sv
// Scoreboard testbench for apb_param_regfile: directed scenarios plus random
// APB traffic checked against an array-based model of the register file.
module tb_apb_param_regfile;

  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 8;
  localparam int WAIT_CYC = 3;
  // reg7..reg0: RO(code 6), RW, W1P, WO, W1S, W1C, RO, RW
  localparam logic [NUM_REGS*3-1:0] REG_TYPE =
    {3'd6, 3'd0, 3'd5, 3'd2, 3'd3, 3'd4, 3'd1, 3'd0};
  localparam logic [NUM_REGS*DATA_W-1:0] RESET_VAL =
    {32'h55AA55AA, 32'h00000000, 32'h00000000, 32'hDEAD0000,
     32'h00000100, 32'h0000000F, 32'hCAFEF00D, 32'h12345678};

  logic                        clk;
  logic                        rst;
  logic [ADDR_W-1:0]           paddr;
  logic                        psel;
  logic                        penable;
  logic                        pwrite;
  logic [DATA_W-1:0]           pwdata;
  logic [DATA_W/8-1:0]         pstrb;
  logic [DATA_W-1:0]           prdata;
  logic                        pready;
  logic                        pslverr;
  logic [NUM_REGS*DATA_W-1:0]  hw_wdata;
  logic [NUM_REGS-1:0]         hw_we;
  logic [NUM_REGS*DATA_W-1:0]  reg_q;
  logic [NUM_REGS-1:0]         wr_pulse;
  logic                        irq;

  apb_param_regfile #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .WAIT_CYC (WAIT_CYC),
    .REG_TYPE (REG_TYPE),
    .RESET_VAL(RESET_VAL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .paddr   (paddr),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .pstrb   (pstrb),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .hw_wdata(hw_wdata),
    .hw_we   (hw_we),
    .reg_q   (reg_q),
    .wr_pulse(wr_pulse),
    .irq     (irq)
  );

  // Model: register contents and access types (0 RW,1 RO,2 WO,3 W1S,4 W1C,5 W1P,6/7 RO)
  logic [31:0] rstv  [NUM_REGS] = '{32'h12345678, 32'hCAFEF00D, 32'h0000000F, 32'h00000100,
                                    32'hDEAD0000, 32'h00000000, 32'h00000000, 32'h55AA55AA};
  int          mtype [NUM_REGS] = '{0, 1, 4, 3, 2, 5, 0, 6};
  logic [31:0] mdl   [NUM_REGS];

  logic [32:0] exp_q [$];   // {prdata, pslverr}
  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_err(input bit wr, input logic [7:0] a);
    int idx;
    idx = int'(a[7:2]);
    if (a[1:0] != 2'b00) return 1'b1;
    if (idx >= NUM_REGS) return 1'b1;
    if (wr && (mtype[idx] == 1 || mtype[idx] >= 6)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] put_lanes(input logic [31:0] v, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = v;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] lane_bits(input logic [31:0] d, input logic [3:0] s);
    return put_lanes(32'h0, d, s);
  endfunction

  // Apply one clock edge's worth of software/hardware updates to the model.
  function automatic void model_commit(input bit sw, input int idx, input logic [31:0] d,
                                       input logic [3:0] s, input int hw_i, input logic [31:0] hw_v);
    for (int r = 0; r < NUM_REGS; r++) begin
      bit hw;
      bit swr;
      logic [31:0] v;
      hw  = (hw_i == r);
      swr = sw && (idx == r);
      v   = mdl[r];
      case (mtype[r])
        0: begin
          if (hw)  v = hw_v;
          if (swr) v = put_lanes(v, d, s);
        end
        2: if (swr) v = put_lanes(v, d, s);
        3: begin
          if (swr) v = v | lane_bits(d, s);
          if (hw)  v = v | hw_v;
        end
        4: begin
          if (swr) v = v & ~lane_bits(d, s);
          if (hw)  v = v | hw_v;
        end
        5: v = swr ? put_lanes(v, d, s) : 32'h0;
        default: if (hw) v = hw_v;
      endcase
      mdl[r] = v;
    end
  endfunction

  task automatic check_regs();
    logic exp_irq;
    exp_irq = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      chk($sformatf("reg_q[%0d]", i), reg_q[i*32 +: 32], mdl[i]);
      if (mtype[i] == 4 && mdl[i] != 32'h0) exp_irq = 1'b1;
    end
    chk("irq", {31'b0, irq}, {31'b0, exp_irq});
  endtask

  // One APB transfer. from_chain: setup phase was already presented in the
  // previous pready cycle. to_chain: present the next setup phase in this
  // pready cycle. rst_commit: assert reset on the would-be commit edge.
  task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int hw_i, input logic [31:0] hw_v,
                      input bit from_chain, input bit to_chain, input bit rst_commit);
    bit          e;
    int          idx;
    int          n;
    logic [31:0] exp_rd;
    logic [7:0]  exp_pulse;
    idx    = int'(a[7:2]);
    e      = is_err(wr, a);
    exp_rd = 32'h0;
    if (!wr && !e) begin
      if (mtype[idx] != 2 && mtype[idx] != 5) exp_rd = mdl[idx];
    end
    exp_q.push_back({exp_rd, e});
    pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    if (!from_chain) begin
      psel = 1'b1; penable = 1'b0;
      @(posedge clk); #1;
    end
    penable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pready !== 1'b1 && n < 50);
    chk("latency", n, WAIT_CYC + 2);
    if (hw_i >= 0) begin
      hw_we[hw_i] = 1'b1;
      hw_wdata[hw_i*32 +: 32] = hw_v;
    end
    if (to_chain) penable = 1'b0;
    if (rst_commit) begin
      #1 rst = 1'b1;
    end
    @(posedge clk); #1;
    hw_we = '0;
    exp_pulse = '0;
    if (rst_commit) begin
      rst = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) mdl[r] = rstv[r];
      chk("pready_after_rst", {31'b0, pready}, 32'h0);
    end else begin
      model_commit(wr && !e, idx, d, s, hw_i, hw_v);
      if (wr && !e) exp_pulse[idx] = 1'b1;
    end
    if (!to_chain) begin
      psel = 1'b0; penable = 1'b0;
    end
    chk("wr_pulse", {24'b0, wr_pulse}, {24'b0, exp_pulse});
    check_regs();
    for (int r = 0; r < NUM_REGS; r++) if (mtype[r] == 5) mdl[r] = 32'h0;
  endtask

  // Monitor: compare each completion against the oldest expected response.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (pready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pready: got pready=1, expected no completion");
        end else begin
          e = exp_q.pop_front();
          chk("prdata", prdata, e[32:1]);
          chk("pslverr", {31'b0, pslverr}, {31'b0, e[0]});
        end
      end
    end
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    bit          chain;
    bit          next_chain;
    int          r;
    logic [7:0]  a;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; hw_wdata = '0; hw_we = '0;
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = rstv[i];
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("reset_pready", {31'b0, pready}, 32'h0);
    chk("reset_pslverr", {31'b0, pslverr}, 32'h0);
    chk("reset_prdata", prdata, 32'h0);
    chk("reset_wr_pulse", {24'b0, wr_pulse}, 32'h0);
    check_regs();

    // Read of reset value
    xfer(1'b0, 8'h00, 32'h0, 4'h0, -1, 32'h0, 1'b0, 1'b0, 1'b0);

    // RW with byte strobes, one-cycle write pulse
    xfer(1'b1, 8'h00, 32'h11223344, 4'hF, -1, 32'h0, 1'b0, 1'b0, 1'b0);
    xfer(1'b1, 8'h00, 32'hAABBCCDD, 4'b0101, -1, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("rw_strobe_value", reg_q[31:0], 32'h11BB33DD);
    @(posedge clk); #1;
    chk("wr_pulse_one_cycle", {24'b0, wr_pulse}, 32'h0);
    xfer(1'b0, 8'h00, 32'h0, 4'h0, -1, 32'h0, 1'b0, 1'b0, 1'b0);

    // W1C with simultaneous hardware set, then full clear
    chk("irq_at_reset", {31'b0, irq}, 32'h1);
    xfer(1'b1, 8'h08, 32'h00000005, 4'hF, 2, 32'h00000001, 1'b0, 1'b0, 1'b0);
    chk("w1c_hw_wins", reg_q[95:64], 32'h0000000B);
    chk("w1c_irq_held", {31'b0, irq}, 32'h1);
    xfer(1'b1, 8'h08, 32'h0000000B, 4'hF, -1, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("w1c_cleared", reg_q[95:64], 32'h0);
    chk("w1c_irq_low", {31'b0, irq}, 32'h0);

    // W1S with hardware OR, WO write and readback
    xfer(1'b1, 8'h0C, 32'h00000003, 4'hF, 3, 32'h00000030, 1'b0, 1'b0, 1'b0);
    xfer(1'b1, 8'h10, 32'hFEEDBEEF, 4'b1100, -1, 32'h0, 1'b0, 1'b0, 1'b0);
    xfer(1'b0, 8'h10, 32'h0, 4'h0, -1, 32'h0, 1'b0, 1'b0, 1'b0);
    xfer(1'b0, 8'h0C, 32'h0, 4'h0, -1, 32'h0, 1'b0, 1'b0, 1'b0);

    // Error responses: RO write, misaligned, out of range
    xfer(1'b1, 8'h04, 32'hFFFFFFFF, 4'hF, -1, 32'h0, 1'b0, 1'b0, 1'b0);
    xfer(1'b0, 8'h02, 32'h0, 4'h0, -1, 32'h0, 1'b0, 1'b0, 1'b0);
    xfer(1'b1, 8'h02, 32'h12121212, 4'hF, -1, 32'h0, 1'b0, 1'b0, 1'b0);
    xfer(1'b0, 8'h20, 32'h0, 4'h0, -1, 32'h0, 1'b0, 1'b0, 1'b0);
    xfer(1'b1, 8'h20, 32'h34343434, 4'hF, -1, 32'h0, 1'b0, 1'b0, 1'b0);
    xfer(1'b1, 8'h1C, 32'h0BADC0DE, 4'hF, -1, 32'h0, 1'b0, 1'b0, 1'b0);

    // Back-to-back write then read without an idle cycle
    xfer(1'b1, 8'h18, 32'h600DF00D, 4'hF, -1, 32'h0, 1'b0, 1'b1, 1'b0);
    xfer(1'b0, 8'h18, 32'h0, 4'h0, -1, 32'h0, 1'b1, 1'b0, 1'b0);

    // W1P pulse, then readback returns zero
    xfer(1'b1, 8'h14, 32'h00000001, 4'hF, -1, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("w1p_high", reg_q[191:160], 32'h1);
    @(posedge clk); #1;
    chk("w1p_cleared", reg_q[191:160], 32'h0);
    xfer(1'b0, 8'h14, 32'h0, 4'h0, -1, 32'h0, 1'b0, 1'b0, 1'b0);

    // Commit with all strobes low still pulses
    xfer(1'b1, 8'h00, 32'hFFFFFFFF, 4'h0, -1, 32'h0, 1'b0, 1'b0, 1'b0);

    // Random traffic with occasional chaining and hardware updates
    chain = 1'b0;
    for (int it = 0; it < 80; it++) begin
      r = int'($urandom_range(0, 9));
      a = 8'(r * 4);
      if ($urandom_range(0, 7) == 0) a = a + 8'($urandom_range(1, 3));
      next_chain = (it != 79) && ($urandom_range(0, 3) == 0);
      xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
           ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1, $urandom,
           chain, next_chain, 1'b0);
      chain = next_chain;
    end

    // Reset on the commit edge: no commit, contents return to reset values
    xfer(1'b1, 8'h18, 32'hA5A5A5A5, 4'hF, -1, 32'h0, 1'b0, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_param_regfile.md
# apb_param_regfile

Parametrised APB4 slave register file, the generalised successor of the generated single-configuration register files. It has NUM_REGS word-aligned registers, each with an access type chosen at elaboration, plus byte strobes, programmable wait states and error responses. Per-register hardware update ports, one-cycle write pulses and a level interrupt built from write-1-to-clear registers connect it to the datapath. It sits between the APB interconnect and block control/status logic.

## Interface
Parameters:
- NUM_REGS, 8, number of registers (1..64); register i is at byte address 4*i
- DATA_W, 32, register and bus data width (multiple of 8)
- ADDR_W, 8, paddr width; must satisfy 2^ADDR_W >= 4*NUM_REGS
- WAIT_CYC, 0, wait states inserted in every access phase (0..15)
- REG_TYPE, all 0, NUM_REGS*3 packed access codes, reg i at [3i+2:3i]: 0 RW, 1 RO, 2 WO, 3 W1S, 4 W1C, 5 W1P; 6 and 7 are treated as RO
- RESET_VAL, all 0, NUM_REGS*DATA_W packed reset values

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  **synchronous, active-high reset**
- paddr  in  ADDR_W  APB address
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  APB direction, 1 = write
- pwdata  in  DATA_W  APB write data
- pstrb  in  DATA_W/8  APB byte strobes
- prdata  out  DATA_W  read data, valid when pready=1
- pready  out  1  transfer completes this cycle
- pslverr  out  1  error response, valid when pready=1
- hw_wdata  in  NUM_REGS*DATA_W  hardware write data or set mask, per register
- hw_we  in  NUM_REGS  hardware write enable, per register
- reg_q  out  NUM_REGS*DATA_W  current register contents; WO and W1P registers are included
- wr_pulse  out  NUM_REGS  one-cycle pulse after an accepted software write to register i
- irq  out  1  OR-reduction of all bits of all W1C registers

## Operation
- FSM has three states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP on psel & !penable.
  - SETUP -> ACCESS unconditionally; the wait counter is loaded with 0.
  - In ACCESS, pready = (cnt == WAIT_CYC). The counter increments while pready=0.
  - ACCESS -> SETUP if the next psel & !penable arrives in the pready cycle (back-to-back transfer); otherwise ACCESS -> IDLE.
  - If psel drops mid-access, the FSM returns to IDLE with no commit.
- Decode: idx = paddr[ADDR_W-1:2].
  - Error if paddr[1:0] != 0, if idx >= NUM_REGS, or on a write to an RO register.
  - An error sets pslverr=1 with pready, prdata=0, and causes no state change.
- Commit happens only in the ACCESS cycle with pready=1. Byte lane b is affected only when pstrb[b]=1.
- Software write per type, on enabled lanes:
  - RW and WO: load pwdata.
  - W1S: reg |= pwdata.
  - W1C: reg &= ~pwdata.
  - W1P: reg = pwdata for one cycle, then clears to 0 the next cycle.
- Reads return the register for RW, RO, W1S and W1C. They return 0 for WO and W1P, with no error. prdata = 0 whenever pready=0.
- Hardware update per type, when hw_we[i]=1:
  - RW and RO: load hw_wdata.
  - W1C and W1S: reg |= hw_wdata.
  - W1P: hw_we is ignored.
- Same-cycle software and hardware update on the same register:
  - RW: software wins.
  - W1C: per bit, hardware set wins over software clear (no event loss).
  - W1S: both are ORed.
- wr_pulse[i] asserts the cycle after any commit to register i, including commits with all pstrb=0. It does not assert on error transfers.

## Timing
- Reset values: FSM in IDLE, cnt=0, every register = RESET_VAL, pready=0, pslverr=0, prdata=0, wr_pulse=0. irq follows the reset contents.
- Reset asserted mid-transfer aborts the transfer with no commit. pready=0 on the following cycle.
- Zero-wait transfer is 2 cycles: SETUP, then ACCESS with pready=1. Each transfer takes WAIT_CYC+2 cycles.
- A written value is visible on reg_q and to readback one cycle after the commit edge. irq updates in the same cycle as reg_q.
- prdata and pslverr are combinational from registered state and the APB inputs; pready is decoded from the registered FSM state.

## Test plan
- Reset to RESET_VAL reg0=0x1234_5678, then zero-wait read of 0x00 -> prdata=0x12345678 at the second cycle, pslverr=0; reg_q matches RESET_VAL for all registers.
- RW reg0, write 0xAABBCCDD with pstrb=4'b0101 over a register holding 0x11223344 -> reads 0x11BB33DD; wr_pulse[0] is high for exactly one cycle.
- W1C reg2 holding 0x0F, irq=1; write 0x05 while hw_we[2]=1 with hw_wdata=0x01 in the same cycle -> reg = 0x0B, irq stays 1; a later write of 0x0B -> reg = 0, irq=0.
- Error cases, each expecting pslverr=1 and no state change: write to RO reg1, access to address 0x02, access to idx NUM_REGS.
- WAIT_CYC=3 -> pready rises exactly 4 cycles after SETUP; two back-to-back transfers complete without passing through IDLE.
- W1P reg5, write 0x1 -> reg_q bit is 1 for one cycle, then 0; readback of reg5 returns 0. rst asserted during ACCESS -> no commit, registers back to RESET_VAL.
